framebuffer_arbiter: RTL and testbench

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

---
 rtl/framebuffer_arbiter.sv | 113 +++++++++++
 tb/tb_framebuffer_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_arbiter.sv
// Framebuffer port arbiter: VGA scanout reads vs host writes, one grant/cycle.
// Optional starvation guard for the host port: define FBARB_STARVE_GUARD_EN.
module framebuffer_arbiter #(
  parameter int ADDR_WIDTH     = 17,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_SCAN_BURST = 8
) (
  input  logic                  system_clock,
  input  logic                  reset_n,
  input  logic                  scan_req,
  input  logic [ADDR_WIDTH-1:0] scan_addr,
  output logic                  scan_ack,
  output logic                  scan_rvalid,
  output logic [DATA_WIDTH-1:0] scan_rdata,
  input  logic                  host_req,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Burst limit clamped into the 8-bit counter range.
  localparam int LP_BURST_I =
    (MAX_SCAN_BURST < 1)   ? 1 :
    (MAX_SCAN_BURST > 255) ? 255 : MAX_SCAN_BURST;
  localparam logic [7:0] LP_BURST = LP_BURST_I[7:0];

  logic                  w_scan_grant;
  logic                  w_host_grant;
  logic                  w_force_host;

  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_rd_p1;
  logic                  r_rvalid;

`ifdef FBARB_STARVE_GUARD_EN
  logic [7:0] r_starve;

  assign w_force_host = host_req && (r_starve >= LP_BURST);

  // Count scan wins while the host waits; saturate at the burst limit.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= 8'd0;
    end else if (!host_req || w_host_grant) begin
      r_starve <= 8'd0;
    end else if (w_scan_grant && (r_starve < LP_BURST)) begin
      r_starve <= r_starve + 8'd1;
    end
  end
`else
  logic w_unused_burst;

  // Strict scan priority: the burst limit has no effect here.
  assign w_unused_burst = ^LP_BURST;
  assign w_force_host   = 1'b0;
`endif

  // Scan wins by default; host wins when scan is idle or guard trips.
  // Both grants are held off while reset is asserted.
  assign w_scan_grant = reset_n & scan_req & ~w_force_host;
  assign w_host_grant = reset_n & host_req
                      & (~scan_req | w_force_host);

  assign scan_ack = w_scan_grant;
  assign host_ack = w_host_grant;

  // Register the winning request onto the memory port.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_scan_grant | w_host_grant;
      r_mem_we <= w_host_grant;
      if (w_host_grant) begin
        r_mem_addr  <= host_addr;
        r_mem_wdata <= host_wdata;
      end else if (w_scan_grant) begin
        r_mem_addr  <= scan_addr;
      end
    end
  end

  // Track scan reads through the memory latency; reset drops them.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_p1  <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_rd_p1  <= w_scan_grant;
      r_rvalid <= r_rd_p1;
    end
  end

  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign scan_rvalid = r_rvalid;
  // Memory data arrives in the response cycle; pass it straight through.
  assign scan_rdata  = r_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Self-checking bench for framebuffer_arbiter.
// Directed vectors, corner sequences and randomized traffic vs a model.
module tb_framebuffer_arbiter;

  localparam int AW   = 17;
  localparam int DW   = 8;
  localparam int MAXB = 8;
`ifdef FBARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scan_req = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic          scan_ack;
  logic          scan_rvalid;
  logic [DW-1:0] scan_rdata;
  logic          host_req = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  framebuffer_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_SCAN_BURST(MAXB)
  ) dut (
    .system_clock(clk),
    .reset_n(rst_n),
    .scan_req(scan_req),
    .scan_addr(scan_addr),
    .scan_ack(scan_ack),
    .scan_rvalid(scan_rvalid),
    .scan_rdata(scan_rdata),
    .host_req(host_req),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_ack(host_ack),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    return (a < 16) ? a[7:0] : (a[7:0] ^ 8'hB5);
  endfunction

  // Synchronous RAM: read data valid the cycle after a sampled read.
  logic [7:0] fbmem [int];
  always @(posedge clk) begin
    if (mem_en && !mem_we)
      mem_rdata <= fbmem.exists(int'(mem_addr)) ?
                   fbmem[int'(mem_addr)] : init_val(mem_addr);
    if (mem_en && mem_we)
      fbmem[int'(mem_addr)] = mem_wdata;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [7:0] data;
  } rsp_t;
  rsp_t          rq[$];
  logic [7:0]    ref_mem [int];
  int            streak = 0;
  bit            e_en = 0;
  bit            e_we = 0;
  logic [AW-1:0] e_addr = '0;
  logic [7:0]    e_wd = '0;

  bit         s_sack, s_hack, s_rv;
  logic [7:0] s_rd;

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // One clock cycle: drive, sample at negedge, check, advance model.
  task automatic step(input bit sr, input logic [AW-1:0] sa,
                      input bit hr, input logic [AW-1:0] ha,
                      input logic [7:0] hd);
    bit hw, sw, erv;
    scan_req = sr; scan_addr = sa;
    host_req = hr; host_addr = ha; host_wdata = hd;
    @(negedge clk);
    cyc++;
    hw = hr && (!sr || (GUARD && streak >= MAXB));
    sw = sr && !hw;
    s_sack = scan_ack; s_hack = host_ack;
    s_rv = scan_rvalid; s_rd = scan_rdata;
    chk("scan_ack", scan_ack, sw);
    chk("host_ack", host_ack, hw);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    if (e_en) chk("mem_addr", mem_addr, e_addr);
    if (e_we) chk("mem_wdata", mem_wdata, e_wd);
    erv = (rq.size() > 0) && (rq[0].due == cyc);
    chk("scan_rvalid", scan_rvalid, erv);
    if (erv) begin
      chk("scan_rdata", scan_rdata, rq[0].data);
      void'(rq.pop_front());
    end
    e_en = sw || hw;
    e_we = hw;
    if (hw) begin
      e_addr = ha; e_wd = hd;
      ref_mem[int'(ha)] = hd;
    end else if (sw) begin
      e_addr = sa;
      rq.push_back('{cyc + 2, ref_rd(sa)});
    end
    if (hw || !hr) streak = 0;
    else if (sw && streak < MAXB) streak++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0);
  endtask

  // Assert reset mid-cycle, check outputs clear at once, then release.
  task automatic do_reset(input bit hold_scan);
    scan_req = hold_scan;
    rst_n = 1'b0;
    #1;
    chk("rst_scan_ack", scan_ack, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_rvalid", scan_rvalid, 0);
    chk("rst_rdata", scan_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_ack", scan_ack, 0);
    chk("rst_hold_en", mem_en, 0);
    scan_req = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rq.delete();
    streak = 0;
    e_en = 0;
    e_we = 0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         sr;
    logic [AW-1:0] sa;
    bit         hr;
    logic [AW-1:0] ha;
    logic [7:0] hd;
    bit         x_sack;
    bit         x_hack;
  } vec_t;

  initial begin
    vec_t vt [8];
    int ns, nh, nboth;
    bit hr;

    vt[0] = '{0, 17'h00000, 0, 17'h00000, 8'h00, 0, 0};
    vt[1] = '{1, 17'h00020, 0, 17'h00000, 8'h00, 1, 0};
    vt[2] = '{0, 17'h00000, 1, 17'h00021, 8'h11, 0, 1};
    vt[3] = '{1, 17'h00022, 1, 17'h00023, 8'h22, 1, 0};
    vt[4] = '{0, 17'h00000, 1, 17'h00023, 8'h22, 0, 1};
    vt[5] = '{1, 17'h00024, 1, 17'h00025, 8'h33, 1, 0};
    vt[6] = '{1, 17'h00025, 0, 17'h00000, 8'h00, 1, 0};
    vt[7] = '{0, 17'h00000, 0, 17'h00000, 8'h00, 0, 0};

    #1;
    do_reset(0);

    // Single scan read of a known word.
    idle(2);
    step(1, 17'h00010, 0, '0, '0);
    chk("rd_ack", s_sack, 1);
    idle(1);
    idle(1);
    chk("rd_rvalid", s_rv, 1);
    chk("rd_rdata", s_rd, 8'hA5);

    // Single host write; no read response may follow.
    step(0, '0, 1, 17'h1F000, 8'h3C);
    chk("wr_ack", s_hack, 1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("wr_no_rvalid", s_rv, 0);
    end

    // Table of short directed vectors.
    for (int i = 0; i < 8; i++) begin
      step(vt[i].sr, vt[i].sa, vt[i].hr, vt[i].ha, vt[i].hd);
      chk($sformatf("vec%0d_sack", i), s_sack, vt[i].x_sack);
      chk($sformatf("vec%0d_hack", i), s_hack, vt[i].x_hack);
    end
    idle(2);

    // Streaming: 16 back-to-back reads, data equals address.
    for (int i = 0; i < 18; i++) begin
      step(i < 16, AW'(i), 0, '0, '0);
      if (i >= 2) begin
        chk("stream_rv", s_rv, 1);
        chk("stream_rd", s_rd, 8'(i - 2));
      end
    end
    idle(1);
    chk("stream_end", s_rv, 0);

    // Contention with both requests held.
    ns = 0; nh = 0; nboth = 0;
`ifdef FBARB_STARVE_GUARD_EN
    for (int i = 0; i < 20; i++) begin
      step(1, AW'(i), 1, AW'(17'h00100 + i), 8'(i));
      ns += int'(s_sack); nh += int'(s_hack);
      nboth += int'(s_sack && s_hack);
      if (i == 8 || i == 17) chk("guard_host_slot", s_hack, 1);
    end
    chk("guard_scan_cnt", ns, 18);
    chk("guard_host_cnt", nh, 2);
`else
    for (int i = 0; i < 100; i++) begin
      step(1, AW'(i), 1, AW'(17'h00100 + i), 8'(i));
      ns += int'(s_sack); nh += int'(s_hack);
      nboth += int'(s_sack && s_hack);
    end
    chk("strict_scan_cnt", ns, 100);
    chk("strict_host_cnt", nh, 0);
`endif
    chk("contend_double_ack", nboth, 0);
    idle(3);

    // Reset in the middle of a scan burst drops in-flight reads.
    step(1, 17'h00030, 0, '0, '0);
    step(1, 17'h00031, 0, '0, '0);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("post_rst_no_rv", s_rv, 0);
    end
    step(1, 17'h00032, 0, '0, '0);
    chk("post_rst_ack", s_sack, 1);
    idle(1);
    chk("post_rst_rv_early", s_rv, 0);
    idle(1);
    chk("post_rst_rv", s_rv, 1);
    chk("post_rst_rd", s_rd, init_val(17'h00032));

    // Randomized traffic with a sticky host request.
    hr = 0;
    for (int i = 0; i < 600; i++) begin
      if (hr) hr = ($urandom_range(0, 99) < 85);
      else    hr = ($urandom_range(0, 99) < 30);
      step($urandom_range(0, 9) < 7, AW'($urandom_range(0, 31)),
           hr, AW'($urandom_range(0, 31)), 8'($urandom));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
